// File: rtl/food_position_generator.sv
// Grid-aligned food placer for the snake playfield: a free-running LFSR feeds
// rejection-sampled candidates to an external occupancy checker, with a bounded retry fallback.
module food_position_generator #(
  parameter int                    LFSR_WIDTH   = 20,
  parameter logic [LFSR_WIDTH-1:0] TAPS         = 20'h00009,
  parameter int                    DEFAULT_SEED = 212701,
  parameter int                    COORD_WIDTH  = 10,
  parameter int                    CELL         = 10,
  parameter int                    COLS         = 64,
  parameter int                    ROWS         = 48,
  parameter int                    MAX_TRIES    = 15,
  parameter int                    FALLBACK_X   = 320,
  parameter int                    FALLBACK_Y   = 240
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_seed_load,
  input  logic [LFSR_WIDTH-1:0]            i_seed,
  input  logic                             i_req,
  output logic [COORD_WIDTH-1:0]           o_check_x,
  output logic [COORD_WIDTH-1:0]           o_check_y,
  output logic                             o_check_valid,
  input  logic                             i_check_ack,
  input  logic                             i_check_blocked,
  output logic [COORD_WIDTH-1:0]           o_pos_x,
  output logic [COORD_WIDTH-1:0]           o_pos_y,
  output logic                             o_pos_valid,
  output logic                             o_busy,
  output logic                             o_fallback,
  output logic [$clog2(MAX_TRIES+1)-1:0]   o_tries
);

  localparam int CB = $clog2(COLS);
  localparam int RB = $clog2(ROWS);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [LFSR_WIDTH-1:0]  SEED_DEF = LFSR_WIDTH'(DEFAULT_SEED);
  localparam logic [TW-1:0]          MAX_T    = TW'(MAX_TRIES);
  localparam logic [COORD_WIDTH-1:0] FB_X     = COORD_WIDTH'(FALLBACK_X);
  localparam logic [COORD_WIDTH-1:0] FB_Y     = COORD_WIDTH'(FALLBACK_Y);
  localparam logic [COORD_WIDTH-1:0] CELL_W   = COORD_WIDTH'(CELL);

  generate
    if (COLS * CELL >= 2 ** COORD_WIDTH) begin : g_bad_cols
      $error("COLS*CELL does not fit in COORD_WIDTH");
    end
    if (ROWS * CELL >= 2 ** COORD_WIDTH) begin : g_bad_rows
      $error("ROWS*CELL does not fit in COORD_WIDTH");
    end
    if (CB + RB > LFSR_WIDTH) begin : g_bad_fields
      $error("column and row fields exceed LFSR_WIDTH");
    end
    if (TAPS == '0) begin : g_bad_taps
      $error("TAPS must be non-zero");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAW     = 3'd1,
    S_CHECK    = 3'd2,
    S_ACCEPT   = 3'd3,
    S_FALLBACK = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LFSR_WIDTH-1:0]   r_lfsr;
  logic                    w_fb;
  logic [CB-1:0]           w_col;
  logic [RB-1:0]           w_row;
  logic                    w_in_range;
  logic [COORD_WIDTH-1:0]  w_cand_x;
  logic [COORD_WIDTH-1:0]  w_cand_y;
  logic [TW-1:0]           w_tries_inc;
  logic                    w_hit_limit;

  logic [COORD_WIDTH-1:0]  w_check_x_nxt;
  logic [COORD_WIDTH-1:0]  w_check_y_nxt;
  logic                    w_check_valid_nxt;
  logic [COORD_WIDTH-1:0]  w_pos_x_nxt;
  logic [COORD_WIDTH-1:0]  w_pos_y_nxt;
  logic                    w_pos_valid_nxt;
  logic                    w_fallback_nxt;
  logic [TW-1:0]           w_tries_nxt;

  assign w_fb        = ^(r_lfsr & TAPS);
  assign w_col       = r_lfsr[CB-1:0];
  assign w_row       = r_lfsr[CB+RB-1:CB];
  assign w_in_range  = (int'(w_col) < COLS) && (int'(w_row) < ROWS);
  assign w_cand_x    = COORD_WIDTH'(w_col) * CELL_W;
  assign w_cand_y    = COORD_WIDTH'(w_row) * CELL_W;
  // Saturating increment; hitting MAX_TRIES on an increment selects the fallback.
  assign w_tries_inc = (o_tries == MAX_T) ? MAX_T : (o_tries + TW'(1));
  assign w_hit_limit = (w_tries_inc == MAX_T);

  // LFSR: free-running in every state, seed load takes priority, zero seed is replaced.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_lfsr <= SEED_DEF;
    end else if (i_seed_load) begin
      r_lfsr <= (i_seed == '0) ? SEED_DEF : i_seed;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[LFSR_WIDTH-1:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; req outside IDLE is dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req) w_state_nxt = S_DRAW;
        else       w_state_nxt = S_IDLE;
      end
      S_DRAW: begin
        if (w_in_range)       w_state_nxt = S_CHECK;
        else if (w_hit_limit) w_state_nxt = S_FALLBACK;
        else                  w_state_nxt = S_DRAW;
      end
      S_CHECK: begin
        if (!i_check_ack)         w_state_nxt = S_CHECK;
        else if (!i_check_blocked) w_state_nxt = S_ACCEPT;
        else if (w_hit_limit)     w_state_nxt = S_FALLBACK;
        else                      w_state_nxt = S_DRAW;
      end
      S_ACCEPT:   w_state_nxt = S_IDLE;
      S_FALLBACK: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs.
  always_comb begin
    w_check_x_nxt     = o_check_x;
    w_check_y_nxt     = o_check_y;
    w_check_valid_nxt = o_check_valid;
    w_pos_x_nxt       = o_pos_x;
    w_pos_y_nxt       = o_pos_y;
    w_pos_valid_nxt   = 1'b0;
    w_fallback_nxt    = o_fallback;
    w_tries_nxt       = o_tries;
    case (r_state)
      S_IDLE: begin
        if (i_req) w_tries_nxt = '0;
        else       w_tries_nxt = o_tries;
      end
      S_DRAW: begin
        if (w_in_range) begin
          w_check_x_nxt     = w_cand_x;
          w_check_y_nxt     = w_cand_y;
          w_check_valid_nxt = 1'b1;
        end else begin
          w_tries_nxt = w_tries_inc;
        end
      end
      S_CHECK: begin
        // Candidate is held until the checker answers; any answer ends the handshake.
        if (i_check_ack) begin
          w_check_valid_nxt = 1'b0;
          if (i_check_blocked) w_tries_nxt = w_tries_inc;
          else                 w_tries_nxt = o_tries;
        end else begin
          w_check_valid_nxt = 1'b1;
        end
      end
      S_ACCEPT: begin
        w_pos_x_nxt       = o_check_x;
        w_pos_y_nxt       = o_check_y;
        w_fallback_nxt    = 1'b0;
        w_check_valid_nxt = 1'b0;
        w_pos_valid_nxt   = 1'b1;
      end
      S_FALLBACK: begin
        w_pos_x_nxt       = FB_X;
        w_pos_y_nxt       = FB_Y;
        w_fallback_nxt    = 1'b1;
        w_check_valid_nxt = 1'b0;
        w_pos_valid_nxt   = 1'b1;
      end
      default: begin
        w_check_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_check_x     <= '0;
      o_check_y     <= '0;
      o_check_valid <= 1'b0;
      o_pos_x       <= '0;
      o_pos_y       <= '0;
      o_pos_valid   <= 1'b0;
      o_busy        <= 1'b0;
      o_fallback    <= 1'b0;
      o_tries       <= '0;
    end else begin
      o_check_x     <= w_check_x_nxt;
      o_check_y     <= w_check_y_nxt;
      o_check_valid <= w_check_valid_nxt;
      o_pos_x       <= w_pos_x_nxt;
      o_pos_y       <= w_pos_y_nxt;
      o_pos_valid   <= w_pos_valid_nxt;
      o_busy        <= (w_state_nxt != S_IDLE);
      o_fallback    <= w_fallback_nxt;
      o_tries       <= w_tries_nxt;
    end
  end

endmodule

// File: tb/tb_food_position_generator.sv
// Self-checking bench for food_position_generator: an LFSR reference model predicts each
// candidate and final result; expected results go to a scoreboard and are compared on pos_valid.
module tb_food_position_generator;

  localparam int COLS = 64, ROWS = 48, CELL = 10, MAX_TRIES = 15;
  localparam logic [19:0] TAPS = 20'h00009;
  localparam logic [19:0] DEF_SEED = 20'd212701;
  localparam logic [9:0] FB_X = 10'd320, FB_Y = 10'd240;

  logic clk = 1'b0;
  logic rst_n, seed_load, req, ack, blocked;
  logic [19:0] seed;
  logic [9:0] check_x, check_y, pos_x, pos_y;
  logic check_valid, pos_valid, busy, fallback;
  logic [3:0] tries;

  food_position_generator dut (
    .i_clock(clk), .i_reset(rst_n), .i_seed_load(seed_load), .i_seed(seed), .i_req(req),
    .o_check_x(check_x), .o_check_y(check_y), .o_check_valid(check_valid),
    .i_check_ack(ack), .i_check_blocked(blocked),
    .o_pos_x(pos_x), .o_pos_y(pos_y), .o_pos_valid(pos_valid),
    .o_busy(busy), .o_fallback(fallback), .o_tries(tries)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    bit         fb;
    int         tries;
  } res_t;

  res_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int pv_count = 0;
  int hs_count = 0;
  logic [19:0] m_lfsr;

  // Reference LFSR, stepped with the same inputs as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         m_lfsr <= DEF_SEED;
    else if (seed_load) m_lfsr <= (seed == 20'd0) ? DEF_SEED : seed;
    else                m_lfsr <= {^(m_lfsr & TAPS), m_lfsr[19:1]};
  end

  // Pulse and handshake counters.
  always @(posedge clk) begin
    if (pos_valid) pv_count <= pv_count + 1;
    if (check_valid && ack) hs_count <= hs_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] adv(input logic [19:0] s);
    return {^(s & TAPS), s[19:1]};
  endfunction

  // Walk DRAW cycles from LFSR value s_in until an in-range candidate or the retry limit.
  task automatic predict(input logic [19:0] s_in, inout int t, output int nrej,
                         output logic [9:0] x, output logic [9:0] y, output bit fb);
    logic [19:0] s;
    s = s_in; nrej = 0; fb = 1'b0; x = 10'd0; y = 10'd0;
    for (int k = 0; k < 64; k++) begin
      if (int'(s[5:0]) < COLS && int'(s[11:6]) < ROWS) begin
        x = 10'(int'(s[5:0]) * CELL);
        y = 10'(int'(s[11:6]) * CELL);
        return;
      end
      t++; nrej++;
      if (t >= MAX_TRIES) begin
        fb = 1'b1;
        return;
      end
      s = adv(s);
    end
  endtask

  task automatic push_fb(input int t);
    res_t e;
    e.x = FB_X; e.y = FB_Y; e.fb = 1'b1; e.tries = t;
    sb_q.push_back(e);
  endtask

  // Issue one request and act as the occupancy checker; expected results go to sb_q.
  task automatic do_request(input int n_block, input int delay, input bit inject,
                            output res_t obs, output int lat, output int hs,
                            output int rr, output int cand_err, output bit timeout);
    int hs0, t, nrej, nblk, wait_c;
    bit pres, done, cfb;
    logic [9:0] cx, cy;
    res_t e;
    hs0 = hs_count; cand_err = 0; timeout = 1'b0; lat = 0; nblk = 0;
    pres = 1'b0; done = 1'b0; rr = 0; wait_c = 0;
    obs.x = 10'd0; obs.y = 10'd0; obs.fb = 1'b0; obs.tries = 0;
    req = 1'b1;
    tick();
    req = 1'b0;
    t = 0;
    predict(m_lfsr, t, nrej, cx, cy, cfb);
    rr += nrej;
    if (cfb) push_fb(t);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (pos_valid) begin
        obs.x = pos_x; obs.y = pos_y; obs.fb = fallback; obs.tries = int'(tries);
        done = 1'b1;
      end else begin
        if (check_valid) begin
          if (!pres) begin
            pres = 1'b1;
            wait_c = delay;
          end
          if (check_x !== cx || check_y !== cy) cand_err++;
        end
        ack = 1'b0; blocked = 1'b0;
        if (pres && check_valid) begin
          if (inject && delay > 1 && wait_c == delay / 2) begin
            req = 1'b1; seed_load = 1'b1; seed = 20'h5A3C1;
          end
          if (wait_c == 0) begin
            ack = 1'b1;
            blocked = (nblk < n_block);
          end else begin
            wait_c--;
          end
        end
        tick();
        lat++;
        req = 1'b0; seed_load = 1'b0;
        if (ack) begin
          pres = 1'b0;
          if (blocked) begin
            nblk++; t++;
            if (t >= MAX_TRIES) begin
              push_fb(t);
            end else begin
              predict(m_lfsr, t, nrej, cx, cy, cfb);
              rr += nrej;
              if (cfb) push_fb(t);
            end
          end else begin
            e.x = cx; e.y = cy; e.fb = 1'b0; e.tries = t;
            sb_q.push_back(e);
          end
          ack = 1'b0; blocked = 1'b0;
        end
      end
    end
    if (!done) timeout = 1'b1;
    hs = hs_count - hs0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; seed_load = 1'b0; seed = 20'd0; req = 1'b0; ack = 1'b0; blocked = 1'b0;
    #12;
    n_checks++;
    if ({check_x, check_y, pos_x, pos_y, tries} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset_coords: got %0d %0d %0d %0d %0d want all 0", check_x, check_y, pos_x, pos_y, tries);
    end
    n_checks++;
    if ({pos_valid, check_valid, busy, fallback} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {pos_valid, check_valid, busy, fallback});
    end
    n_checks++;
    if (dut.r_lfsr !== DEF_SEED) begin
      n_fail++;
      $display("FAIL reset_lfsr: got %0d want %0d", dut.r_lfsr, DEF_SEED);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_seed_zero();
    seed_load = 1'b1; seed = 20'd0;
    tick();
    seed_load = 1'b0;
    n_checks++;
    if (dut.r_lfsr !== 20'd212701) begin
      n_fail++;
      $display("FAIL seed_zero: got %0d want 212701", dut.r_lfsr);
    end
    tick();
  endtask

  task automatic test_basic();
    res_t obs, e;
    int lat, hs, rr, ce, pv0;
    bit to;
    seed_load = 1'b1; seed = 20'hABCDE;
    tick();
    seed_load = 1'b0;
    pv0 = pv_count;
    do_request(0, 0, 1'b0, obs, lat, hs, rr, ce, to);
    tick(); tick();
    n_checks++;
    if (to || sb_q.size() == 0) begin
      n_fail++; $display("FAIL basic_done: timeout=%0d sb=%0d want result", to, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (obs.x !== e.x || obs.y !== e.y || obs.fb !== e.fb || obs.tries != e.tries) begin
        n_fail++;
        $display("FAIL basic_result: got (%0d,%0d) fb=%0d tries=%0d want (%0d,%0d) fb=%0d tries=%0d",
                 obs.x, obs.y, obs.fb, obs.tries, e.x, e.y, e.fb, e.tries);
      end
      n_checks++;
      if (lat != 3 + rr) begin
        n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, 3 + rr);
      end
    end
    n_checks++;
    if ((obs.x % 10) != 0 || obs.x >= 10'd640 || (obs.y % 10) != 0 || obs.y >= 10'd480 || obs.fb !== 1'b0) begin
      n_fail++; $display("FAIL basic_grid: got (%0d,%0d) fb=%0d want grid-aligned on field", obs.x, obs.y, obs.fb);
    end
    n_checks++;
    if (pv_count - pv0 != 1 || ce != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse: pv=%0d cand_err=%0d busy=%0d want 1 0 0", pv_count - pv0, ce, busy);
    end
  endtask

  task automatic test_blocked3();
    res_t obs, e;
    int lat, hs, rr, ce, pv0;
    bit to;
    pv0 = pv_count;
    do_request(3, 0, 1'b0, obs, lat, hs, rr, ce, to);
    tick(); tick();
    n_checks++;
    if (to || sb_q.size() == 0) begin
      n_fail++; $display("FAIL blk3_done: timeout=%0d sb=%0d want result", to, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (obs.x !== e.x || obs.y !== e.y || obs.fb !== e.fb || obs.tries != e.tries) begin
        n_fail++;
        $display("FAIL blk3_result: got (%0d,%0d) fb=%0d tries=%0d want (%0d,%0d) fb=%0d tries=%0d",
                 obs.x, obs.y, obs.fb, obs.tries, e.x, e.y, e.fb, e.tries);
      end
      n_checks++;
      if (hs != MAX_TRIES - rr && e.fb) begin
        n_fail++; $display("FAIL blk3_hs_fb: got %0d want %0d", hs, MAX_TRIES - rr);
      end else if (hs != 4 && !e.fb) begin
        n_fail++; $display("FAIL blk3_hs: got %0d want 4", hs);
      end
    end
    n_checks++;
    if (pv_count - pv0 != 1 || ce != 0) begin
      n_fail++; $display("FAIL blk3_pulse: pv=%0d cand_err=%0d want 1 0", pv_count - pv0, ce);
    end
  endtask

  task automatic test_all_blocked();
    res_t obs, e;
    int lat, hs, rr, ce, pv0;
    bit to;
    pv0 = pv_count;
    do_request(1000, 0, 1'b0, obs, lat, hs, rr, ce, to);
    tick(); tick();
    n_checks++;
    if (to || obs.x !== 10'd320 || obs.y !== 10'd240 || obs.fb !== 1'b1 || obs.tries != 15) begin
      n_fail++;
      $display("FAIL fallback_result: got (%0d,%0d) fb=%0d tries=%0d to=%0d want (320,240) fb=1 tries=15",
               obs.x, obs.y, obs.fb, obs.tries, to);
    end
    n_checks++;
    if (hs != MAX_TRIES - rr) begin
      n_fail++; $display("FAIL fallback_handshakes: got %0d want %0d", hs, MAX_TRIES - rr);
    end
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++; $display("FAIL fallback_sb: got empty want entry");
    end else begin
      e = sb_q.pop_front();
      if (e.fb !== obs.fb || e.tries != obs.tries) begin
        n_fail++; $display("FAIL fallback_sb: got fb=%0d tries=%0d want fb=%0d tries=%0d", obs.fb, obs.tries, e.fb, e.tries);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || pv_count - pv0 != 1 || tries !== 4'd15) begin
      n_fail++; $display("FAIL fallback_idle: busy=%0d pv=%0d tries=%0d want 0 1 15", busy, pv_count - pv0, tries);
    end
  endtask

  task automatic test_delay_inject();
    res_t obs, e;
    int lat, hs, rr, ce, pv0;
    bit to;
    pv0 = pv_count;
    do_request(1, 7, 1'b1, obs, lat, hs, rr, ce, to);
    repeat (4) tick();
    n_checks++;
    if (ce != 0) begin
      n_fail++; $display("FAIL inject_stable: got %0d candidate deviations want 0", ce);
    end
    n_checks++;
    if (to || sb_q.size() == 0) begin
      n_fail++; $display("FAIL inject_done: timeout=%0d sb=%0d want result", to, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (obs.x !== e.x || obs.y !== e.y || obs.fb !== e.fb || obs.tries != e.tries) begin
        n_fail++;
        $display("FAIL inject_result: got (%0d,%0d) fb=%0d tries=%0d want (%0d,%0d) fb=%0d tries=%0d",
                 obs.x, obs.y, obs.fb, obs.tries, e.x, e.y, e.fb, e.tries);
      end
    end
    n_checks++;
    if (pv_count - pv0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL inject_single: pv=%0d busy=%0d want 1 0", pv_count - pv0, busy);
    end
  endtask

  task automatic test_stray_ack();
    int pv0;
    logic [3:0] t0;
    logic [9:0] px;
    pv0 = pv_count; t0 = tries; px = pos_x;
    ack = 1'b1; blocked = 1'b1;
    repeat (3) tick();
    blocked = 1'b0;
    repeat (3) tick();
    ack = 1'b0;
    tick();
    n_checks++;
    if (pv_count - pv0 != 0 || busy !== 1'b0 || check_valid !== 1'b0 || tries !== t0 || pos_x !== px) begin
      n_fail++;
      $display("FAIL stray_ack: pv=%0d busy=%0d cv=%0d tries=%0d pos_x=%0d want 0 0 0 %0d %0d",
               pv_count - pv0, busy, check_valid, tries, pos_x, t0, px);
    end
  endtask

  task automatic test_reset_mid();
    res_t obs, e;
    int lat, hs, rr, ce, pv0, n;
    bit to;
    req = 1'b1;
    tick();
    req = 1'b0;
    n = 0;
    while (!check_valid && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (!check_valid) begin
      n_fail++; $display("FAIL rstmid_reach: got check_valid=0 want 1 within 40 cycles");
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({check_x, check_y, pos_x, pos_y, tries, pos_valid, check_valid, busy, fallback} !== 48'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got cx=%0d cy=%0d px=%0d py=%0d t=%0d flags=%b want all 0",
               check_x, check_y, pos_x, pos_y, tries, {pos_valid, check_valid, busy, fallback});
    end
    tick();
    pv0 = pv_count;
    rst_n = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (pv_count - pv0 != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_abandon: pv=%0d busy=%0d want 0 0", pv_count - pv0, busy);
    end
    do_request(0, 0, 1'b0, obs, lat, hs, rr, ce, to);
    tick();
    n_checks++;
    if (to || sb_q.size() == 0) begin
      n_fail++; $display("FAIL rstmid_next: timeout=%0d sb=%0d want result", to, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (obs.x !== e.x || obs.y !== e.y || obs.fb !== e.fb || obs.tries != e.tries || lat != 3 + rr) begin
        n_fail++;
        $display("FAIL rstmid_next: got (%0d,%0d) fb=%0d tries=%0d lat=%0d want (%0d,%0d) fb=%0d tries=%0d lat=%0d",
                 obs.x, obs.y, obs.fb, obs.tries, lat, e.x, e.y, e.fb, e.tries, 3 + rr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seed_zero();
    test_basic();
    test_blocked3();
    test_all_blocked();
    test_delay_inject();
    test_stray_ack();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
